// File: rtl/unsigned_fixed_point_divider.sv
// Unsigned fixed-point divider: Quotient = floor((A<<F)/B), Remainder = (A<<F) mod B.
// Restoring division, one quotient bit per cycle, MSB first, over W+F cycles.
module unsigned_fixed_point_divider #(
    parameter int W = 4,
    parameter int F = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   Quotient,
    output logic [W-1:0]     Remainder,
    output logic             div_by_zero
);

    localparam int N  = W + F;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_dvd;
    logic [W-1:0]    r_rem;
    logic [W-1:0]    r_b;

    logic [W:0]      w_trial;
    logic            w_ge;
    logic [W-1:0]    w_rem_nxt;
    logic [N-1:0]    w_dvd_nxt;

    // r_dvd shifts dividend bits out of its MSB while quotient bits enter at its LSB.
    assign w_trial   = {r_rem, r_dvd[N-1]};
    assign w_ge      = (w_trial >= {1'b0, r_b});
    assign w_rem_nxt = w_ge ? (w_trial[W-1:0] - r_b) : w_trial[W-1:0];
    assign w_dvd_nxt = {r_dvd[N-2:0], w_ge};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            Quotient    <= '0;
            Remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (B == '0) begin
                            r_state     <= DONE;
                            done        <= 1'b1;
                            Quotient    <= '1;
                            Remainder   <= '0;
                            div_by_zero <= 1'b1;
                        end else begin
                            r_state <= CALC;
                            r_cnt   <= '0;
                        end
                    end
                end
                CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state     <= DONE;
                        done        <= 1'b1;
                        Quotient    <= {{(2*W-N){1'b0}}, w_dvd_nxt};
                        Remainder   <= w_rem_nxt;
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Operands are captured once at start so later input changes cannot disturb the divide.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && start) begin
            r_dvd <= {A, {F{1'b0}}};
            r_rem <= '0;
            r_b   <= B;
        end else if (r_state == CALC) begin
            r_dvd <= w_dvd_nxt;
            r_rem <= w_rem_nxt;
        end
    end

endmodule

// File: tb/tb_unsigned_fixed_point_divider.sv
// Directed bench for unsigned_fixed_point_divider at W=4, F=2.
module tb_unsigned_fixed_point_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] A = 4'h0;
    logic [3:0] B = 4'h0;
    logic       busy;
    logic       done;
    logic [7:0] Quotient;
    logic [3:0] Remainder;
    logic       div_by_zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    unsigned_fixed_point_divider #(.W(4), .F(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .Quotient(Quotient),
        .Remainder(Remainder), .div_by_zero(div_by_zero)
    );

    // Pulses start for one cycle, scrambles A/B afterwards, and returns the
    // cycles from the start-sampling edge to done (-1 if done never came).
    task automatic run_div(input logic [3:0] a, input logic [3:0] b,
                           output int lat, output logic [7:0] q,
                           output logic [3:0] r, output logic z);
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; A = ~a; B = ~b;
        lat = -1; q = 8'h00; r = 4'h0; z = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i; q = Quotient; r = Remainder; z = div_by_zero;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; A = 4'h6; B = 4'h2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, Quotient, Remainder, div_by_zero} !== 15'h0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b Q=%h R=%h dbz=%b, want all 0",
                     busy, done, Quotient, Remainder, div_by_zero);
        end
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_ignored: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_basic();
        logic [3:0] va [4] = '{4'h6, 4'hF, 4'h1, 4'h0};
        logic [3:0] vb [4] = '{4'h2, 4'h1, 4'h3, 4'h5};
        logic [7:0] vq [4] = '{8'h0C, 8'h3C, 8'h01, 8'h00};
        logic [3:0] vr [4] = '{4'h0, 4'h0, 4'h1, 4'h0};
        int lat; logic [7:0] q; logic [3:0] r; logic z;
        for (int i = 0; i < 4; i++) begin
            run_div(va[i], vb[i], lat, q, r, z);
            checks++;
            if (lat !== 7) begin
                errors++;
                $display("FAIL basic_latency[%0d]: got %0d, want 7", i, lat);
            end
            checks++;
            if ({q, r, z} !== {vq[i], vr[i], 1'b0}) begin
                errors++;
                $display("FAIL basic_result[%0d]: Q=%h R=%h dbz=%b, want Q=%h R=%h dbz=0",
                         i, q, r, z, vq[i], vr[i]);
            end
            @(negedge clk);
            checks++;
            if ({busy, done, Quotient, Remainder} !== {2'b00, vq[i], vr[i]}) begin
                errors++;
                $display("FAIL basic_hold[%0d]: busy=%b done=%b Q=%h R=%h, want 0 0 %h %h",
                         i, busy, done, Quotient, Remainder, vq[i], vr[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat; logic [7:0] q; logic [3:0] r; logic z;
        run_div(4'h5, 4'h0, lat, q, r, z);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL dz_latency: got %0d, want 1", lat);
        end
        checks++;
        if ({q, r, z} !== {8'hFF, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL dz_result: Q=%h R=%h dbz=%b, want FF 0 1", q, r, z);
        end
        run_div(4'h6, 4'h2, lat, q, r, z);
        checks++;
        if ({q, r, z} !== {8'h0C, 4'h0, 1'b0} || lat !== 7) begin
            errors++;
            $display("FAIL dz_clear: lat=%0d Q=%h R=%h dbz=%b, want 7 0C 0 0", lat, q, r, z);
        end
    endtask

    task automatic test_back_to_back();
        int lat1 = -1;
        int lat2 = -1;
        logic [7:0] q1 = 8'h00;
        logic [7:0] q2 = 8'h00;
        logic busy_mid = 1'b0;
        @(negedge clk);
        A = 4'h6; B = 4'h2; start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 2) begin A = 4'hF; B = 4'h1; end
            if (i == 3) busy_mid = busy;
            if (done) begin lat1 = i; q1 = Quotient; break; end
        end
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin lat2 = i; q2 = Quotient; break; end
        end
        start = 1'b0;
        checks++;
        if (busy_mid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_busy: busy=%b mid-calc, want 1", busy_mid);
        end
        checks++;
        if (lat1 !== 7 || q1 !== 8'h0C) begin
            errors++;
            $display("FAIL b2b_first: lat=%0d Q=%h, want 7 0C", lat1, q1);
        end
        checks++;
        if (lat2 !== 8 || q2 !== 8'h3C) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d Q=%h, want 8 3C", lat2, q2);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b after start dropped, want 0", busy);
        end
    endtask

    task automatic test_reset_mid_calc();
        int lat; logic [7:0] q; logic [3:0] r; logic z;
        int seen = 0;
        logic busy_pre;
        run_div(4'h1, 4'h3, lat, q, r, z);
        @(negedge clk);
        A = 4'hF; B = 4'h1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        busy_pre = busy;
        rst_n = 1'b0; start = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy_pre, busy, done, Quotient, Remainder, div_by_zero} !== 16'h8000) begin
            errors++;
            $display("FAIL abort_outputs: busy_before=%b busy=%b done=%b Q=%h R=%h dbz=%b, want 1 then all 0",
                     busy_pre, busy, done, Quotient, Remainder, div_by_zero);
        end
        rst_n = 1'b1; start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_done: %0d active cycles after abort, want 0", seen);
        end
        run_div(4'h8, 4'h4, lat, q, r, z);
        checks++;
        if ({q, r, z} !== {8'h08, 4'h0, 1'b0} || lat !== 7) begin
            errors++;
            $display("FAIL abort_recover: lat=%0d Q=%h R=%h dbz=%b, want 7 08 0 0", lat, q, r, z);
        end
    endtask

    task automatic test_sweep();
        int lat; logic [7:0] q; logic [3:0] r; logic z;
        int n, eq, er, el; logic ez;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_div(4'(a), 4'(b), lat, q, r, z);
                n = a * 4;
                if (b == 0) begin eq = 255; er = 0; ez = 1'b1; el = 1; end
                else begin eq = n / b; er = n % b; ez = 1'b0; el = 7; end
                checks++;
                if (int'(q) !== eq || int'(r) !== er || z !== ez || lat !== el) begin
                    errors++;
                    $display("FAIL sweep A=%h B=%h: lat=%0d Q=%h R=%h dbz=%b, want lat=%0d Q=%h R=%h dbz=%b",
                             a, b, lat, q, r, z, el, eq, er, ez);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_calc();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
